// File: rtl/sdram_arbit_pkg.sv
// Shared constants for the SDRAM arbiter: command encodings, state type, watchdog default.
package sdram_arbit_pkg;

  // {CS#,RAS#,CAS#,WE#}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;

  localparam int unsigned TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM controller arbiter: grants the bus to init, refresh, write or read and muxes
// the granted source onto the SDRAM pins. Priority refresh > write > read.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ar_req,
  input  logic              ar_end,
  input  logic [3:0]        ar_cmd,
  input  logic [BANK_W-1:0] ar_bank,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ar_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              arb_err,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_dq_oe,
  output logic [DATA_W-1:0] sdram_dq_out
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              grant_end;
  logic              wdog_hit;
  logic [3:0]        pin_cmd;
  logic [BANK_W-1:0] pin_ba;
  logic [ADDR_W-1:0] pin_addr;

  always_comb begin
    grant_end = 1'b0;
    case (state_q)
      ST_AREF:  grant_end = ar_end;
      ST_WRITE: grant_end = wr_end;
      ST_READ:  grant_end = rd_end;
      default:  grant_end = 1'b0;
    endcase
  end

  // An end pulse in the timeout cycle takes precedence over the watchdog.
  assign wdog_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !grant_end;

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          cnt_q <= '0;
          if (init_end) state_q <= ST_ARBIT;
        end
        ST_ARBIT: begin
          cnt_q <= '0;
          if (ar_req)      state_q <= ST_AREF;
          else if (wr_req) state_q <= ST_WRITE;
          else if (rd_req) state_q <= ST_READ;
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          cnt_q <= cnt_q + 1'b1;
          if (grant_end) begin
            state_q <= ST_ARBIT;
          end else if (wdog_hit) begin
            state_q <= ST_ARBIT;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_ARBIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ar_en   = (state_q == ST_AREF);
  assign wr_en   = (state_q == ST_WRITE);
  assign rd_en   = (state_q == ST_READ);
  assign arb_err = err_q;

  // Pins are forced to NOP while reset is asserted, even though INIT normally passes init_*.
  always_comb begin
    pin_cmd  = CMD_NOP;
    pin_ba   = '1;
    pin_addr = '1;
    if (arb_rst_n) begin
      case (state_q)
        ST_INIT:  begin pin_cmd = init_cmd; pin_ba = init_bank; pin_addr = init_addr; end
        ST_AREF:  begin pin_cmd = ar_cmd;   pin_ba = ar_bank;   pin_addr = ar_addr;   end
        ST_WRITE: begin pin_cmd = wr_cmd;   pin_ba = wr_bank;   pin_addr = wr_addr;   end
        ST_READ:  begin pin_cmd = rd_cmd;   pin_ba = rd_bank;   pin_addr = rd_addr;   end
        default:  begin pin_cmd = CMD_NOP;  pin_ba = '1;        pin_addr = '1;        end
      endcase
    end
  end

  assign sdram_cke    = 1'b1;
  assign sdram_cs_n   = pin_cmd[3];
  assign sdram_ras_n  = pin_cmd[2];
  assign sdram_cas_n  = pin_cmd[1];
  assign sdram_we_n   = pin_cmd[0];
  assign sdram_ba     = pin_ba;
  assign sdram_addr   = pin_addr;
  assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_data : '0;

endmodule
